// File: rtl/sw_select_debounce_pkg.sv
// Shared types and constants for the slide-switch conditioner.
// Holds the per-bit debounce FSM encoding and timing defaults.
package sw_select_debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        WAIT   = 1'b1
    } db_state_e;

    localparam int unsigned DEBOUNCE_10MS_AT_25MHZ = 250000;
    localparam int unsigned SYNC_STAGES            = 2;

endpackage

// File: rtl/sw_select_debounce_bit.sv
// One switch bit: 2-flop synchroniser, debounce FSM and counter,
// registered rise/fall pulses.
// Ports: clk25, n_reset, raw_i (async pin), db_o (debounced level),
//        rise_o / fall_o (1-cycle pulses on db_o edges).
module sw_debounce_bit
    import sw_select_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_AT_25MHZ,
    parameter int unsigned CNT_W           = 18
) (
    input  logic clk25,
    input  logic n_reset,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s2;

    assign s2 = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk25 or negedge n_reset) begin
        if (!n_reset) begin
            sync_q  <= '0;
            state_q <= STABLE;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // cnt counts consecutive samples of the new level; the sample that
    // would make it DEBOUNCE_CYCLES commits the toggle instead.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (s2 != db_q) begin
                    state_d = WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT: begin
                if (s2 == db_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    db_d    = s2;
                    rise_d  = s2;
                    fall_d  = ~s2;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/sw_select_debounce.sv
// Slide-switch conditioner: per-bit debounce plus a one-hot select stage.
// Ports: clk25, n_reset, sw_raw in; sw_db, sw_rise, sw_fall, sel,
//        sel_valid, sel_change out (all registered).
module sw_select_debounce
    import sw_select_debounce_pkg::*;
#(
    parameter int unsigned N_SW            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_AT_25MHZ,
    parameter int unsigned CNT_W           = 18
) (
    input  logic            clk25,
    input  logic            n_reset,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_db,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic [N_SW-1:0] sel,
    output logic            sel_valid,
    output logic            sel_change
);

    localparam int unsigned PC_W = $clog2(N_SW + 1);

    logic [N_SW-1:0] sel_q, sel_d;
    logic            valid_q, valid_d;
    logic            chg_q, chg_d;
    logic [PC_W-1:0] ones;

    for (genvar g = 0; g < N_SW; g++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk25  (clk25),
            .n_reset(n_reset),
            .raw_i  (sw_raw[g]),
            .db_o   (sw_db[g]),
            .rise_o (sw_rise[g]),
            .fall_o (sw_fall[g])
        );
    end

    always_comb begin
        ones = '0;
        for (int i = 0; i < N_SW; i++) begin
            ones = ones + PC_W'(sw_db[i]);
        end
        valid_d = (ones == PC_W'(1));
        sel_d   = valid_d ? sw_db : '0;
        chg_d   = (sel_d != sel_q);
    end

    always_ff @(posedge clk25 or negedge n_reset) begin
        if (!n_reset) begin
            sel_q   <= '0;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = valid_q;
    assign sel_change = chg_q;

endmodule

// File: tb/tb_sw_select_debounce.sv
// Bench for sw_select_debounce with a short debounce window (4 cycles).
// Directed scenarios plus random switch activity against a level-age model.
module tb_sw_select_debounce;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk25 = 1'b0;
    logic         n_reset = 1'b0;
    logic [N-1:0] sw_raw = '0;
    logic [N-1:0] sw_db, sw_rise, sw_fall, sel;
    logic         sel_valid, sel_change;

    sw_select_debounce #(
        .N_SW           (N),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk25     (clk25),
        .n_reset   (n_reset),
        .sw_raw    (sw_raw),
        .sw_db     (sw_db),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_change(sel_change)
    );

    always #20 clk25 = ~clk25;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: a synchronised level is accepted once it has been seen on
    // D consecutive edges while differing from the debounced level.
    logic [N-1:0] m_p1, m_p2, m_seen, m_prev, m_db;
    logic [N-1:0] m_rise, m_fall, m_sel, m_nsel;
    logic         m_valid, m_chg;
    int           m_age[N];

    task automatic model_step();
        if (!n_reset) begin
            m_p1 = '0; m_p2 = '0; m_prev = '0; m_db = '0;
            m_rise = '0; m_fall = '0; m_sel = '0;
            m_valid = 1'b0; m_chg = 1'b0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
        end else begin
            m_valid = ($countones(m_db) == 1);
            m_nsel  = m_valid ? m_db : '0;
            m_chg   = (m_nsel != m_sel);
            m_sel   = m_nsel;
            m_seen  = m_p2;
            m_p2    = m_p1;
            m_p1    = sw_raw;
            m_rise  = '0;
            m_fall  = '0;
            for (int i = 0; i < N; i++) begin
                if (m_seen[i] == m_prev[i])
                    m_age[i] = (m_age[i] < D) ? m_age[i] + 1 : D;
                else
                    m_age[i] = 1;
                m_prev[i] = m_seen[i];
                if (m_seen[i] != m_db[i] && m_age[i] >= D) begin
                    m_db[i] = m_seen[i];
                    if (m_seen[i]) m_rise[i] = 1'b1;
                    else           m_fall[i] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge clk25 or negedge n_reset);
            model_step();
        end
    end

    initial forever begin
        @(negedge clk25);
        if (cmp_en) begin
            chk("db",     sw_db,      m_db);
            chk("rise",   sw_rise,    m_rise);
            chk("fall",   sw_fall,    m_fall);
            chk("sel",    sel,        m_sel);
            chk("valid",  sel_valid,  m_valid);
            chk("change", sel_change, m_chg);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk25);
    endtask

    int rises;

    initial begin
        cyc(3);
        cmp_en = 1'b1;
        chk("rst_db", sw_db, 0);
        chk("rst_sel", {sel, sel_valid, sel_change}, 0);
        n_reset = 1'b1;
        cyc(3);

        // single switch: latency and select follow-up
        sw_raw = 4'b0001;
        cyc(5);
        chk("lat_early_db", sw_db, 4'b0000);
        cyc(1);
        chk("lat_db", sw_db, 4'b0001);
        chk("lat_rise", sw_rise, 4'b0001);
        cyc(1);
        chk("sel1", sel, 4'b0001);
        chk("sel1_valid", sel_valid, 1);
        chk("sel1_chg", sel_change, 1);
        chk("rise_1cyc", sw_rise, 0);
        cyc(1);
        chk("sel1_chg_end", sel_change, 0);

        // bounce on bit 1
        rises = 0;
        for (int k = 0; k < 4; k++) begin
            sw_raw[1] = (k % 2 == 0);
            repeat (2) begin
                cyc(1);
                if (sw_rise[1]) rises++;
            end
        end
        sw_raw[1] = 1'b1;
        repeat (5) begin
            cyc(1);
            if (sw_rise[1]) rises++;
        end
        chk("bounce_early", rises, 0);
        cyc(1);
        chk("bounce_rise", sw_rise, 4'b0010);
        chk("bounce_db", sw_db, 4'b0011);
        cyc(1);
        chk("two_sel", sel, 0);
        chk("two_valid", sel_valid, 0);
        chk("two_chg", sel_change, 1);

        // release bit 0
        sw_raw = 4'b0010;
        cyc(6);
        chk("rel_fall", sw_fall, 4'b0001);
        cyc(1);
        chk("rel_sel", sel, 4'b0010);
        chk("rel_chg", sel_change, 1);

        // simultaneous raise of bits 2 and 3
        sw_raw = 4'b0000;
        cyc(10);
        sw_raw = 4'b1100;
        cyc(6);
        chk("sim_rise", sw_rise, 4'b1100);
        cyc(1);
        chk("sim_sel", {sel, sel_valid, sel_change}, 0);

        // reset during a pending transition on bit 0
        sw_raw = 4'b1101;
        cyc(4);
        #2 n_reset = 1'b0;
        #1 chk("rst_mid_db", sw_db, 0);
        chk("rst_mid_pulse", {sw_rise, sw_fall}, 0);
        cyc(2);
        n_reset = 1'b1;
        cyc(5);
        chk("rst_relat_early", sw_db, 0);
        cyc(1);
        chk("rst_relat_db", sw_db, 4'b1101);
        chk("rst_relat_rise", sw_rise, 4'b1101);

        // window boundary: D-1 rejected, D accepted
        sw_raw = 4'b0000;
        cyc(10);
        rises = 0;
        sw_raw[2] = 1'b1;
        cyc(D - 1);
        sw_raw[2] = 1'b0;
        repeat (10) begin
            cyc(1);
            if (sw_rise[2]) rises++;
        end
        chk("short_pulse", rises, 0);
        sw_raw[2] = 1'b1;
        cyc(D);
        sw_raw[2] = 1'b0;
        repeat (10) begin
            cyc(1);
            if (sw_rise[2]) rises++;
        end
        chk("full_pulse", rises, 1);

        // random activity
        for (int t = 0; t < 400; t++) begin
            sw_raw = sw_raw ^ 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0)
                cyc($urandom_range(1, 3));
            else
                cyc($urandom_range(3, 10));
            if ($urandom_range(0, 60) == 0) begin
                #2 n_reset = 1'b0;
                cyc(2);
                n_reset = 1'b1;
            end
        end
        cyc(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
